// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: both requester ports, the data-memory side and
// the error flag. The arbiter connects through the slave modport, and the
// requesters and memory connect through the master modport.
interface dmem_arbiter_if;
  // Port A: pipeline MEM stage, priority requester
  logic        a_req;
  logic        a_wena;
  logic [31:0] a_addr;
  logic [1:0]  a_type;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_stall;
  logic        a_rvalid;
  logic [31:0] a_rdata;

  // Port B: debug/loader DMA requester
  logic        b_req;
  logic        b_wena;
  logic [31:0] b_addr;
  logic [1:0]  b_type;
  logic [31:0] b_wdata;
  logic        b_lock;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;

  // Single-port data memory
  logic        mem_ena;
  logic        mem_wena;
  logic [31:0] mem_addr;
  logic [1:0]  mem_type;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        err;

  modport slave (
    input  a_req, a_wena, a_addr, a_type, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata,
    input  b_req, b_wena, b_addr, b_type, b_wdata, b_lock,
    output b_gnt, b_rvalid, b_rdata,
    output mem_ena, mem_wena, mem_addr, mem_type, mem_wdata,
    input  mem_rdata,
    output err
  );

  modport master (
    output a_req, a_wena, a_addr, a_type, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata,
    output b_req, b_wena, b_addr, b_type, b_wdata, b_lock,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_ena, mem_wena, mem_addr, mem_type, mem_wdata,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// (port A, priority) and the debug/loader DMA (port B). Grants are decided
// combinationally each cycle; read data returns registered one cycle later.
// Optional macro DMEM_ARB_STARVE_EN: forces a B grant after MAX_WAIT cycles
// of B waiting, so B cannot be starved by continuous A traffic.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 2048,
  parameter int unsigned LOCK_MAX = 8,
  parameter int unsigned MAX_WAIT = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  if (LOCK_MAX < 1 || MAX_WAIT < 1) begin : g_bad_params
    $error("dmem_arbiter: LOCK_MAX and MAX_WAIT must be at least 1");
  end

  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_t;

  state_t            state;
  logic [LOCK_W-1:0] lock_cnt;

  logic        gnt_a;
  logic        gnt_b;
  logic        lock_hold;
  logic        force_b;
  logic        any_gnt;
  logic        illegal;
  logic        legal_acc;
  logic        win_wena;
  logic [31:0] win_addr;
  logic [1:0]  win_type;
  logic [31:0] win_wdata;

  logic        a_rvalid_q;
  logic [31:0] a_rdata_q;
  logic        b_rvalid_q;
  logic [31:0] b_rdata_q;
  logic        err_q;

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  assign force_b = bus.b_req && (wait_cnt == WAIT_W'(MAX_WAIT));
`else
  assign force_b = 1'b0;
`endif

  // B keeps the memory while it holds b_lock and the lock budget remains
  assign lock_hold = (state == OWN_B) && bus.b_req && bus.b_lock &&
                     (lock_cnt < LOCK_W'(LOCK_MAX));

  // Grant decision. Outside an active lock every state shares the same
  // priority order (A over B), so the per-state cases collapse into one
  // chain. No grant is issued while reset is asserted.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (lock_hold || force_b) begin
        gnt_b = 1'b1;
      end else if (bus.a_req) begin
        gnt_a = 1'b1;
      end else if (bus.b_req) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Select the winning port's access fields
  always_comb begin
    win_wena  = 1'b0;
    win_addr  = '0;
    win_type  = '0;
    win_wdata = '0;
    if (gnt_a) begin
      win_wena  = bus.a_wena;
      win_addr  = bus.a_addr;
      win_type  = bus.a_type;
      win_wdata = bus.a_wdata;
    end else if (gnt_b) begin
      win_wena  = bus.b_wena;
      win_addr  = bus.b_addr;
      win_type  = bus.b_type;
      win_wdata = bus.b_wdata;
    end
  end

  assign any_gnt   = gnt_a | gnt_b;
  assign illegal   = any_gnt && ((win_type == 2'b11) || (win_addr >= 32'(DEPTH)));
  assign legal_acc = any_gnt && !illegal;

  // Memory side: an illegal access still consumes the grant but never
  // reaches the memory; all lines idle at zero when nothing is granted
  assign bus.mem_ena   = legal_acc;
  assign bus.mem_wena  = legal_acc & win_wena;
  assign bus.mem_addr  = legal_acc ? win_addr  : '0;
  assign bus.mem_type  = legal_acc ? win_type  : '0;
  assign bus.mem_wdata = legal_acc ? win_wdata : '0;

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_stall  = bus.a_req & ~gnt_a;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.err      = err_q;

  // Ownership FSM, lock/wait counters and registered read-return/error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
      err_q      <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt   <= '0;
`endif
    end else begin
      if (gnt_a) begin
        state <= OWN_A;
      end else if (gnt_b) begin
        state <= OWN_B;
      end else begin
        state <= IDLE;
      end

      lock_cnt <= lock_hold ? lock_cnt + LOCK_W'(1) : '0;

      err_q <= illegal;

      a_rvalid_q <= gnt_a && legal_acc && !bus.a_wena;
      if (gnt_a && legal_acc && !bus.a_wena) begin
        a_rdata_q <= bus.mem_rdata;
      end

      b_rvalid_q <= gnt_b && legal_acc && !bus.b_wena;
      if (gnt_b && legal_acc && !bus.b_wena) begin
        b_rdata_q <= bus.mem_rdata;
      end

`ifdef DMEM_ARB_STARVE_EN
      if (gnt_b) begin
        wait_cnt <= '0;
      end else if (bus.b_req) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data
// memory (negedge write, combinational read) and read-data scoreboards.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 2048;
  localparam int unsigned LOCK_MAX = 8;
  localparam int unsigned MAX_WAIT = 16;

  logic clk;
  logic rst_n;

  dmem_arbiter_if dif ();

  dmem_arbiter #(
    .DEPTH   (DEPTH),
    .LOCK_MAX(LOCK_MAX),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  logic [31:0] mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: writes land on the falling edge of the grant cycle
  always @(negedge clk) begin
    if (dif.mem_ena && dif.mem_wena) begin
      case (dif.mem_type)
        2'b00:   mem[dif.mem_addr[10:0]]       <= dif.mem_wdata;
        2'b01:   mem[dif.mem_addr[10:0]][15:0] <= dif.mem_wdata[15:0];
        default: mem[dif.mem_addr[10:0]][7:0]  <= dif.mem_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    dif.mem_rdata = '0;
    if (dif.mem_ena) dif.mem_rdata = mem[dif.mem_addr[10:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest expected word
  always @(posedge clk) begin
    #1;
    if (dif.a_rvalid) begin
      vectors++;
      assert (qa.size() != 0) else begin
        miscompares++;
        $error("FAIL a_rvalid_unexpected observed=1 expected=0");
      end
      if (qa.size() != 0) chk("a_rdata", dif.a_rdata, qa.pop_front());
    end
    if (dif.b_rvalid) begin
      vectors++;
      assert (qb.size() != 0) else begin
        miscompares++;
        $error("FAIL b_rvalid_unexpected observed=1 expected=0");
      end
      if (qb.size() != 0) chk("b_rdata", dif.b_rdata, qb.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic wena, input logic [31:0] addr,
                         input logic [1:0] typ, input logic [31:0] wdata);
    dif.a_req   = req;
    dif.a_wena  = wena;
    dif.a_addr  = addr;
    dif.a_type  = typ;
    dif.a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic wena, input logic [31:0] addr,
                         input logic [1:0] typ, input logic [31:0] wdata, input logic lock);
    dif.b_req   = req;
    dif.b_wena  = wena;
    dif.b_addr  = addr;
    dif.b_type  = typ;
    dif.b_wdata = wdata;
    dif.b_lock  = lock;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int first;
    logic a_after;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_a_rvalid", {31'b0, dif.a_rvalid}, 1'b0);
    chk("rst_b_rvalid", {31'b0, dif.b_rvalid}, 1'b0);
    chk("rst_err", {31'b0, dif.err}, 1'b0);
    chk("rst_a_rdata", dif.a_rdata, 32'h0);
    chk("rst_b_rdata", dif.b_rdata, 32'h0);
    chk("rst_mem_ena", {31'b0, dif.mem_ena}, 1'b0);
    rst_n = 1'b1;
    cyc();

    // A write then read of the same word
    drive_a(1, 1, 5, 2'b00, 32'hDEADBEEF);
    #1;
    chk("wr_a_gnt", {31'b0, dif.a_gnt}, 1'b1);
    chk("wr_a_stall", {31'b0, dif.a_stall}, 1'b0);
    chk("wr_mem_wena", {31'b0, dif.mem_wena}, 1'b1);
    chk("wr_mem_addr", dif.mem_addr, 32'd5);
    chk("wr_mem_wdata", dif.mem_wdata, 32'hDEADBEEF);
    cyc();
    drive_a(1, 0, 5, 2'b00, 0);
    #1;
    chk("rd_a_gnt", {31'b0, dif.a_gnt}, 1'b1);
    chk("rd_a_stall", {31'b0, dif.a_stall}, 1'b0);
    chk("rd_mem_wena", {31'b0, dif.mem_wena}, 1'b0);
    qa.push_back(32'hDEADBEEF);
    cyc();
    chk("rd_a_rvalid", {31'b0, dif.a_rvalid}, 1'b1);
    drive_a(0, 0, 0, 0, 0);
    cyc();
    chk("rd_a_rvalid_pulse", {31'b0, dif.a_rvalid}, 1'b0);
    chk("rd_a_rdata_hold", dif.a_rdata, 32'hDEADBEEF);

    // Back-to-back A: write, read-after-write, then two reads
    drive_a(1, 1, 7, 2'b00, 32'h11112222);
    cyc();
    drive_a(1, 0, 7, 2'b00, 0);
    qa.push_back(32'h11112222);
    cyc();
    drive_a(1, 0, 5, 2'b00, 0);
    qa.push_back(32'hDEADBEEF);
    cyc();
    drive_a(1, 0, 7, 2'b00, 0);
    qa.push_back(32'h11112222);
    cyc();
    drive_a(0, 0, 0, 0, 0);
    cyc();

    // Simultaneous requests from IDLE: A wins, B follows when A drops
    drive_a(1, 0, 5, 2'b00, 0);
    drive_b(1, 1, 32'h40, 2'b00, 32'hCAFEF00D, 0);
    #1;
    chk("both_a_gnt", {31'b0, dif.a_gnt}, 1'b1);
    chk("both_b_gnt", {31'b0, dif.b_gnt}, 1'b0);
    qa.push_back(32'hDEADBEEF);
    cyc();
    drive_a(0, 0, 0, 0, 0);
    #1;
    chk("b_after_a_gnt", {31'b0, dif.b_gnt}, 1'b1);
    chk("b_mem_addr", dif.mem_addr, 32'h40);
    cyc();
    drive_b(1, 0, 32'h40, 2'b00, 0, 0);
    #1;
    chk("b_rd_gnt", {31'b0, dif.b_gnt}, 1'b1);
    qb.push_back(32'hCAFEF00D);
    cyc();
    drive_b(0, 0, 0, 0, 0, 0);
    cyc();

    // Lock burst: entry grant plus LOCK_MAX extensions, A stalled meanwhile
    drive_b(1, 1, 32'h41, 2'b00, 32'h0, 1);
    #1;
    chk("lock_entry_b_gnt", {31'b0, dif.b_gnt}, 1'b1);
    cyc();
    drive_a(1, 0, 5, 2'b00, 0);
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!dif.b_gnt) break;
      nb++;
      chk("lock_a_stall", {31'b0, dif.a_stall}, 1'b1);
      cyc();
    end
    chk("lock_burst_len", 32'(nb), 32'(LOCK_MAX + 1));
    chk("lock_release_a_gnt", {31'b0, dif.a_gnt}, 1'b1);
    qa.push_back(32'hDEADBEEF);
    cyc();
    drive_a(0, 0, 0, 0, 0);
    #1;
    chk("lock_b_regrant", {31'b0, dif.b_gnt}, 1'b1);
    cyc();
    drive_b(0, 0, 0, 0, 0, 0);
    cyc();

    // Boundary word and illegal accesses
    drive_a(1, 1, DEPTH - 1, 2'b00, 32'h0BADF00D);
    #1;
    chk("top_word_mem_ena", {31'b0, dif.mem_ena}, 1'b1);
    cyc();
    drive_a(1, 0, DEPTH - 1, 2'b00, 0);
    qa.push_back(32'h0BADF00D);
    cyc();
    chk("top_word_err", {31'b0, dif.err}, 1'b0);
    drive_a(1, 0, 3, 2'b11, 0);
    #1;
    chk("ill_type_a_gnt", {31'b0, dif.a_gnt}, 1'b1);
    chk("ill_type_mem_ena", {31'b0, dif.mem_ena}, 1'b0);
    cyc();
    chk("ill_type_err", {31'b0, dif.err}, 1'b1);
    chk("ill_type_rvalid", {31'b0, dif.a_rvalid}, 1'b0);
    drive_a(1, 0, DEPTH, 2'b00, 0);
    #1;
    chk("ill_addr_mem_ena", {31'b0, dif.mem_ena}, 1'b0);
    chk("ill_addr_mem_wena", {31'b0, dif.mem_wena}, 1'b0);
    cyc();
    chk("ill_addr_err", {31'b0, dif.err}, 1'b1);
    chk("ill_addr_rvalid", {31'b0, dif.a_rvalid}, 1'b0);
    drive_a(0, 0, 0, 0, 0);
    cyc();
    chk("ill_err_clear", {31'b0, dif.err}, 1'b0);

    // Continuous contention: B is either forced in once or starved
    drive_a(1, 1, 10, 2'b00, 32'h1);
    drive_b(1, 1, 32'h50, 2'b00, 32'h2, 0);
    nb = 0;
    first = 0;
    a_after = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      #1;
      if (dif.b_gnt) begin
        nb++;
        if (first == 0) first = i;
      end
      if (i == int'(MAX_WAIT) + 2) a_after = dif.a_gnt;
      cyc();
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve_first_b_gnt", 32'(first), 32'(MAX_WAIT + 1));
    chk("starve_b_gnt_count", 32'(nb), 32'd1);
`else
    chk("starve_first_b_gnt", 32'(first), 32'd0);
    chk("starve_b_gnt_count", 32'(nb), 32'd0);
`endif
    chk("starve_a_resumes", {31'b0, a_after}, 1'b1);
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    cyc();

    // Reset during a locked B read burst with a read in flight
    drive_b(1, 0, 32'h40, 2'b00, 0, 1);
    #1;
    chk("rst_burst_gnt0", {31'b0, dif.b_gnt}, 1'b1);
    qb.push_back(32'hCAFEF00D);
    cyc();
    #1;
    chk("rst_burst_gnt1", {31'b0, dif.b_gnt}, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b_gnt", {31'b0, dif.b_gnt}, 1'b0);
    chk("mid_rst_a_gnt", {31'b0, dif.a_gnt}, 1'b0);
    chk("mid_rst_mem_ena", {31'b0, dif.mem_ena}, 1'b0);
    chk("mid_rst_mem_addr", dif.mem_addr, 32'h0);
    chk("mid_rst_b_rvalid", {31'b0, dif.b_rvalid}, 1'b0);
    chk("mid_rst_b_rdata", dif.b_rdata, 32'h0);
    chk("mid_rst_err", {31'b0, dif.err}, 1'b0);
    drive_b(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_b_rvalid", {31'b0, dif.b_rvalid}, 1'b0);
    cyc();
    cyc();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Port A is the pipeline MEM stage and has priority. Port B is the debug/loader DMA port.
- Drives the data memory control, address and write-data lines from the winning port in the grant cycle; the memory commits writes on the falling edge of that cycle.
- Registers read data back to the winner one cycle later. Generates the MEM-stage stall and flags illegal accesses.

Parameters:
- DEPTH, 2048: number of 32-bit words in the data memory; word index range is 0..DEPTH-1.
- LOCK_MAX, 8: maximum number of consecutive cycles B may hold the memory with b_lock.
- MAX_WAIT, 16: B wait-cycle threshold for forced grant (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  MEM-stage access request.
- a_wena  input  1  1 = write, 0 = read.
- a_addr  input  32  word index.
- a_type  input  2  00 word, 01 half (low 16 bits), 10 byte (low 8 bits), 11 illegal.
- a_wdata  input  32  write data.
- a_gnt  output  1  combinational; A owns the memory this cycle.
- a_stall  output  1  a_req & ~a_gnt.
- a_rvalid  output  1  registered; read data valid.
- a_rdata  output  32  registered read data.
- b_req, b_wena, b_addr[31:0], b_type[1:0], b_wdata[31:0], b_lock  input  same meanings as A; b_lock requests to keep ownership.
- b_gnt, b_rvalid, b_rdata[31:0]  output  same meanings as A.
- mem_ena, mem_wena  output  1  memory enable and write enable.
- mem_addr  output  32  memory word index.
- mem_type  output  2  memory access type.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  combinational memory read data.
- err  output  1  registered one-cycle pulse on an illegal access.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lock_cnt=0, wait_cnt=0. a_rvalid, b_rvalid, err=0. a_rdata, b_rdata=0.
- Outputs while no grant: gnt=0 and all mem_* driven to 0, never z.
- FSM states: IDLE, OWN_A, OWN_B. Grant is decided combinationally from the current state and requests.
- IDLE: a_req → grant A, next OWN_A. Else b_req → grant B, next OWN_B. Else stay IDLE.
- OWN_A: a_req → grant A, stay. Else b_req → grant B, next OWN_B. Else next IDLE.
- OWN_B, b_req & b_lock & lock_cnt<LOCK_MAX → grant B, stay, lock_cnt++. A stalls.
- OWN_B otherwise: a_req → grant A, next OWN_A, lock_cnt=0. Else b_req → grant B, stay, lock_cnt=0. Else next IDLE, lock_cnt=0.
- When lock_cnt reaches LOCK_MAX: the next cycle with a_req grants A.
- Granted cycle, normal access: mem_ena=1, mem_wena=winner wena, and mem_addr/type/wdata = winner's fields.
- Illegal access (type==11 or addr>=DEPTH): mem_ena=0, mem_wena=0, and the posedge sets err=1 for one cycle. The grant still counts; no rvalid is produced.
- Read latency: a granted legal read with wena=0 sets rvalid=1 at the next posedge, with rdata=mem_rdata sampled at that edge. rvalid lasts exactly one cycle. rdata holds its value until the next valid read.
- Write: committed by the memory on the negedge of the grant cycle. No rvalid.
- A read granted in the cycle after a write to the same address returns the new data.
- Back-to-back grants to the same port: one access per cycle, full throughput.
- Reset asserted mid-lock or mid-read: the FSM goes to IDLE immediately and any pending rvalid is dropped.

Optional Feature:
- Macro: DMEM_ARB_STARVE_EN.
- Defined:
  - wait_cnt increments each cycle that b_req=1 and b_gnt=0, and clears on b_gnt.
  - When wait_cnt==MAX_WAIT, that cycle grants B regardless of a_req; the state becomes OWN_B and A stalls.
  - wait_cnt then clears.
- Undefined: strict A priority. B may starve indefinitely. wait_cnt logic is absent.

Test Plan:
- Reset, then A writes word 0xDEADBEEF to addr 5, then A reads addr 5. Expect a_gnt=1 in both cycles, a_rvalid=1 one cycle after the read with a_rdata=0xDEADBEEF, and a_stall=0 throughout.
- a_req and b_req high together from IDLE. Expect a_gnt=1, b_gnt=0. A drops → b_gnt=1 the next cycle, with mem_addr equal to b_addr.
- B in OWN_B with b_lock=1, and a_req held high. Expect b_gnt for exactly LOCK_MAX+1 consecutive cycles (the entry grant plus LOCK_MAX lock-extension grants; default 9), a_stall=1 throughout, then a_gnt=1.
- A access with type=11, then A access with addr=2048. Expect err to pulse once for each, mem_ena=0 in both grant cycles, and no a_rvalid.
- With DMEM_ARB_STARVE_EN: a_req held high, b_req held high. Expect b_gnt=1 on cycle MAX_WAIT+1 (17) for one cycle, then A resumes. Without the macro, b_gnt stays 0.
- Assert rst_n=0 during a B lock burst with a read in flight. Expect all outputs 0 immediately, state IDLE, and no rvalid after rst_n is released.
